// File: rtl/channel_device.sv
// channel_device: device-side responder for the parallel channel "A" interface
// Ports:
//   aclk, aresetn            clock, asynchronous active-low reset
//   enable                   0 = never respond, always propagate select
//   a_bus_out(_parity)       channel-to-device bus, odd parity
//   a_*_out tags             channel tags, asynchronous, synchronized here
//   a_bus_in(_parity)        device-to-channel bus, odd parity generated here
//   a_*_in tags              device tags, registered
//   cmd_tdata/cmd_tvalid     latched command byte with a 1-cycle valid pulse
//   recv_*                   bytes written by the channel, one-deep holding register
//   send_*                   bytes read by the channel
//   busy, parity_error       operational indication, sticky parity flag
module channel_device #(
    parameter logic [7:0] DEVICE_ADDR = 8'h40
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       enable,
    input  logic [7:0] a_bus_out,
    input  logic       a_bus_out_parity,
    input  logic       a_operational_out,
    input  logic       a_hold_out,
    input  logic       a_select_out,
    input  logic       a_address_out,
    input  logic       a_command_out,
    input  logic       a_service_out,
    input  logic       a_suppress_out,
    output logic [7:0] a_bus_in,
    output logic       a_bus_in_parity,
    output logic       a_operational_in,
    output logic       a_select_in,
    output logic       a_address_in,
    output logic       a_status_in,
    output logic       a_service_in,
    output logic       a_request_in,
    output logic [7:0] cmd_tdata,
    output logic       cmd_tvalid,
    output logic [7:0] recv_tdata,
    output logic       recv_tvalid,
    input  logic       recv_tready,
    input  logic [7:0] send_tdata,
    input  logic       send_tvalid,
    output logic       send_tready,
    input  logic       send_tlast,
    output logic       busy,
    output logic       parity_error
);
    localparam logic [2:0] IDLE        = 3'd0;
    localparam logic [2:0] SELECTED    = 3'd1;
    localparam logic [2:0] CMD_WAIT    = 3'd2;
    localparam logic [2:0] INIT_STATUS = 3'd3;
    localparam logic [2:0] DATA_W      = 3'd4;
    localparam logic [2:0] DATA_R      = 3'd5;
    localparam logic [2:0] END_STATUS  = 3'd6;
    localparam logic [2:0] DISCONNECT  = 3'd7;

    logic [4:0] sync1, sync2;
    logic       s_op, s_sel, s_adr, s_cmd, s_svc;
    logic [2:0] state, ph;
    logic       op_in, sel_in, adr_in, sts_in, svc_in, acc_cmd, tlast_q;
    logic [7:0] bus_in, status_byte;
    logic       bus_ok, hit, unused;

    assign unused = a_suppress_out;
    assign {s_op, s_sel, s_adr, s_cmd, s_svc} = sync2;
    assign bus_ok = ^{a_bus_out, a_bus_out_parity};
    assign hit = enable && s_sel && s_adr && bus_ok && a_bus_out == DEVICE_ADDR;
    assign status_byte = state == INIT_STATUS ? (cmd_tdata[1:0] == 2'b00 ? 8'h0C : 8'h00)
                                              : (parity_error ? 8'h0E : 8'h0C);

    assign a_bus_in         = bus_in;
    // gated by op_in so the bus reads all-zero while not connected
    assign a_bus_in_parity  = op_in & ~^bus_in;
    assign a_operational_in = op_in;
    assign a_select_in      = sel_in;
    assign a_address_in     = adr_in;
    assign a_status_in      = sts_in;
    assign a_service_in     = svc_in;
    assign a_request_in     = 1'b0;
    assign busy             = op_in;

    // hold_out is treated as an alias of select_out
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {a_operational_out, a_select_out | a_hold_out, a_address_out, a_command_out, a_service_out};
            sync2 <= sync1;
        end
    end

    // ph is a per-state sub-step; ph 4 in the data states waits for a stop command_out to fall
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            {state, ph, op_in, sel_in, adr_in, sts_in, svc_in, acc_cmd, tlast_q} <= '0;
            {bus_in, cmd_tdata, cmd_tvalid, recv_tdata, recv_tvalid, send_tready, parity_error} <= '0;
        end else if (!s_op) begin
            {state, ph, op_in, sel_in, adr_in, sts_in, svc_in, acc_cmd, tlast_q} <= '0;
            {bus_in, cmd_tdata, cmd_tvalid, recv_tdata, recv_tvalid, send_tready, parity_error} <= '0;
        end else begin
            cmd_tvalid  <= 1'b0;
            send_tready <= 1'b0;
            if (recv_tvalid && recv_tready) recv_tvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (hit) begin
                        state        <= SELECTED;
                        op_in        <= 1'b1;
                        bus_in       <= DEVICE_ADDR;
                        parity_error <= 1'b0;
                        sel_in       <= 1'b0;
                    end else begin
                        sel_in <= s_sel;
                    end
                end
                SELECTED: begin
                    adr_in <= 1'b1;
                    ph     <= 3'd0;
                    state  <= CMD_WAIT;
                end
                CMD_WAIT: begin
                    if (ph == 3'd0) begin
                        if (s_cmd) begin
                            cmd_tdata  <= a_bus_out;
                            cmd_tvalid <= 1'b1;
                            adr_in     <= 1'b0;
                            ph         <= 3'd1;
                            if (!bus_ok) parity_error <= 1'b1;
                        end
                    end else if (!s_cmd) begin
                        ph    <= 3'd0;
                        state <= INIT_STATUS;
                    end
                end
                INIT_STATUS, END_STATUS: begin
                    if (ph == 3'd0) begin
                        bus_in <= status_byte;
                        ph     <= 3'd1;
                    end else if (ph == 3'd1) begin
                        sts_in <= 1'b1;
                        ph     <= 3'd2;
                    end else if (ph == 3'd2) begin
                        if (s_svc || s_cmd) begin
                            sts_in  <= 1'b0;
                            acc_cmd <= s_cmd;
                            ph      <= 3'd3;
                        end
                    end else if (!(acc_cmd ? s_cmd : s_svc)) begin
                        ph    <= 3'd0;
                        state <= state == END_STATUS || cmd_tdata[1:0] == 2'b00 ? DISCONNECT :
                                 cmd_tdata[1:0] == 2'b11 ? END_STATUS :
                                 cmd_tdata[1:0] == 2'b01 ? DATA_W : DATA_R;
                    end
                end
                DATA_W, DATA_R: begin
                    if (ph == 3'd4) begin
                        if (!s_cmd) begin
                            ph    <= 3'd0;
                            state <= END_STATUS;
                        end
                    end else if (s_cmd) begin
                        svc_in <= 1'b0;
                        ph     <= 3'd4;
                    end else if (state == DATA_W) begin
                        if (ph == 3'd0) begin
                            if (!recv_tvalid) begin
                                svc_in <= 1'b1;
                                ph     <= 3'd1;
                            end
                        end else if (ph == 3'd1) begin
                            if (s_svc) begin
                                recv_tdata  <= a_bus_out;
                                recv_tvalid <= 1'b1;
                                svc_in      <= 1'b0;
                                ph          <= 3'd2;
                                if (!bus_ok) parity_error <= 1'b1;
                            end
                        end else if (!s_svc) begin
                            ph <= 3'd0;
                        end
                    end else begin
                        if (ph == 3'd0) begin
                            if (send_tvalid) begin
                                send_tready <= 1'b1;
                                bus_in      <= send_tdata;
                                tlast_q     <= send_tlast;
                                ph          <= 3'd1;
                            end
                        end else if (ph == 3'd1) begin
                            svc_in <= 1'b1;
                            ph     <= 3'd2;
                        end else if (ph == 3'd2) begin
                            if (s_svc) begin
                                svc_in <= 1'b0;
                                ph     <= 3'd3;
                            end
                        end else if (!s_svc) begin
                            ph <= 3'd0;
                            if (tlast_q) state <= END_STATUS;
                        end
                    end
                end
                default: begin
                    op_in  <= 1'b0;
                    bus_in <= 8'h00;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_channel_device.sv
// tb_channel_device: self-checking bench acting as the channel and the local backend
module tb_channel_device;
    logic       aclk = 1'b0, aresetn = 1'b1, enable = 1'b1;
    logic [7:0] a_bus_out = 8'h00;
    logic       a_bus_out_parity = 1'b1;
    logic       a_operational_out = 1'b0, a_hold_out = 1'b0, a_select_out = 1'b0, a_address_out = 1'b0;
    logic       a_command_out = 1'b0, a_service_out = 1'b0, a_suppress_out = 1'b0;
    logic [7:0] a_bus_in, cmd_tdata, recv_tdata;
    logic       a_bus_in_parity, a_operational_in, a_select_in, a_address_in, a_status_in, a_service_in, a_request_in;
    logic       cmd_tvalid, recv_tvalid, send_tready, busy, parity_error;
    logic       recv_tready = 1'b0;
    logic [7:0] send_tdata = 8'h00;
    logic       send_tvalid = 1'b0, send_tlast = 1'b0;
    logic [35:0] outs;
    int errors = 0, checks = 0;
    logic [7:0] exp_q[$], recv_q[$];
    logic [8:0] send_q[$];
    logic hs_pend = 1'b0, cmd_seen = 1'b0;

    channel_device #(.DEVICE_ADDR(8'h40)) dut (
        .aclk(aclk), .aresetn(aresetn), .enable(enable),
        .a_bus_out(a_bus_out), .a_bus_out_parity(a_bus_out_parity),
        .a_operational_out(a_operational_out), .a_hold_out(a_hold_out), .a_select_out(a_select_out),
        .a_address_out(a_address_out), .a_command_out(a_command_out), .a_service_out(a_service_out),
        .a_suppress_out(a_suppress_out),
        .a_bus_in(a_bus_in), .a_bus_in_parity(a_bus_in_parity),
        .a_operational_in(a_operational_in), .a_select_in(a_select_in), .a_address_in(a_address_in),
        .a_status_in(a_status_in), .a_service_in(a_service_in), .a_request_in(a_request_in),
        .cmd_tdata(cmd_tdata), .cmd_tvalid(cmd_tvalid),
        .recv_tdata(recv_tdata), .recv_tvalid(recv_tvalid), .recv_tready(recv_tready),
        .send_tdata(send_tdata), .send_tvalid(send_tvalid), .send_tready(send_tready), .send_tlast(send_tlast),
        .busy(busy), .parity_error(parity_error)
    );

    assign outs = {a_bus_in, a_bus_in_parity, a_operational_in, a_select_in, a_address_in, a_status_in,
                   a_service_in, a_request_in, cmd_tdata, cmd_tvalid, recv_tdata, recv_tvalid,
                   send_tready, busy, parity_error};

    always #5 aclk = ~aclk;

    // one clock; the backend advances after each completed send handshake
    task automatic tick();
        @(posedge aclk);
        #1;
        if (hs_pend) begin
            if (send_q.size() > 0) begin
                {send_tlast, send_tdata} = send_q.pop_front();
                send_tvalid = 1'b1;
            end else begin
                send_tvalid = 1'b0;
            end
        end
        hs_pend = send_tvalid && send_tready;
        if (cmd_tvalid) cmd_seen = 1'b1;
    endtask

    task automatic load_send();
        {send_tlast, send_tdata} = send_q.pop_front();
        send_tvalid = 1'b1;
        hs_pend = 1'b0;
    endtask

    task automatic flush_send();
        send_q.delete();
        send_tvalid = 1'b0;
        hs_pend = 1'b0;
    endtask

    function automatic logic tag(input int i);
        return i == 0 ? a_operational_in : i == 1 ? a_address_in : i == 2 ? a_status_in :
               i == 3 ? a_service_in : a_select_in;
    endfunction

    task automatic wait_tag(input int i, input logic v, input string nm);
        int n = 0;
        while (tag(i) !== v && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (tag(i) !== v) begin
            errors++;
            $display("FAIL %s: tag %0d is %b after %0d cycles, required %b", nm, i, tag(i), n, v);
        end
    endtask

    task automatic check_bus(input string nm);
        logic [7:0] e;
        e = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (a_bus_in !== e || a_bus_in_parity !== ~^e) begin
            errors++;
            $display("FAIL %s: bus_in=%h parity=%b, required %h parity=%b", nm, a_bus_in, a_bus_in_parity, e, ~^e);
        end
    endtask

    task automatic select_dev(input logic [7:0] a);
        a_bus_out = a;
        a_bus_out_parity = ~^a;
        a_address_out = 1'b1;
        tick();
        a_select_out = 1'b1;
        a_hold_out = 1'b1;
        wait_tag(1, 1'b1, "address_in rise");
        check_bus("selection byte");
        a_address_out = 1'b0;
        a_select_out = 1'b0;
        a_hold_out = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] c);
        a_bus_out = c;
        a_bus_out_parity = ~^c;
        cmd_seen = 1'b0;
        a_command_out = 1'b1;
        wait_tag(1, 1'b0, "address_in drop");
        checks++;
        if (cmd_seen !== 1'b1 || cmd_tdata !== c) begin
            errors++;
            $display("FAIL command latch: cmd_tvalid seen=%b cmd_tdata=%h, required 1 and %h", cmd_seen, cmd_tdata, c);
        end
        a_command_out = 1'b0;
    endtask

    task automatic status(input logic use_cmd, input string nm);
        wait_tag(2, 1'b1, nm);
        check_bus(nm);
        if (use_cmd) a_command_out = 1'b1;
        else a_service_out = 1'b1;
        wait_tag(2, 1'b0, nm);
        a_command_out = 1'b0;
        a_service_out = 1'b0;
    endtask

    task automatic read_byte(input string nm);
        wait_tag(3, 1'b1, nm);
        check_bus(nm);
        a_service_out = 1'b1;
        wait_tag(3, 1'b0, nm);
        a_service_out = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, input logic ok);
        logic [7:0] e;
        wait_tag(3, 1'b1, "write service_in");
        a_bus_out = d;
        a_bus_out_parity = ok ? ~^d : ^d;
        recv_q.push_back(d);
        a_service_out = 1'b1;
        wait_tag(3, 1'b0, "write service_in drop");
        e = recv_q.pop_front();
        checks++;
        if (recv_tvalid !== 1'b1 || recv_tdata !== e) begin
            errors++;
            $display("FAIL recv byte: valid=%b data=%h, required 1 and %h", recv_tvalid, recv_tdata, e);
        end
        a_service_out = 1'b0;
        repeat (6) tick();
        checks++;
        if (a_service_in !== 1'b0) begin
            errors++;
            $display("FAIL recv full hold: service_in=%b, required 0", a_service_in);
        end
        recv_tready = 1'b1;
        tick();
        recv_tready = 1'b0;
        checks++;
        if (recv_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL recv release: recv_tvalid=%b, required 0", recv_tvalid);
        end
    endtask

    task automatic stop_xfer();
        wait_tag(3, 1'b1, "stop service_in");
        a_command_out = 1'b1;
        wait_tag(3, 1'b0, "stop service_in drop");
        a_command_out = 1'b0;
    endtask

    task automatic check_pe(input logic v, input string nm);
        checks++;
        if (parity_error !== v) begin
            errors++;
            $display("FAIL %s: parity_error=%b, required %b", nm, parity_error, v);
        end
    endtask

    task automatic check_outs_zero(input string nm);
        checks++;
        if (outs !== 36'h0) begin
            errors++;
            $display("FAIL %s: outputs=%h, required 0", nm, outs);
        end
    endtask

    task automatic test_reset();
        #1 aresetn = 1'b0;
        repeat (3) tick();
        check_outs_zero("reset outputs");
        aresetn = 1'b1;
        a_operational_out = 1'b1;
        repeat (4) tick();
        check_outs_zero("idle outputs");
    endtask

    task automatic test_read();
        exp_q = '{8'h40, 8'h00, 8'hA1, 8'hB2, 8'hC3, 8'h0C};
        send_q = '{{1'b0, 8'hA1}, {1'b0, 8'hB2}, {1'b1, 8'hC3}};
        load_send();
        select_dev(8'h40);
        send_cmd(8'h02);
        status(1'b0, "read initial status");
        repeat (3) read_byte("read data");
        status(1'b0, "read ending status");
        wait_tag(0, 1'b0, "read op_in drop");
        checks++;
        if (send_tvalid !== 1'b0 || send_q.size() != 0) begin
            errors++;
            $display("FAIL read backend drained: send_tvalid=%b left=%0d, required 0 and 0", send_tvalid, send_q.size());
        end
        repeat (4) tick();
    endtask

    task automatic test_write();
        exp_q = '{8'h40, 8'h00, 8'h0C};
        select_dev(8'h40);
        send_cmd(8'h01);
        status(1'b0, "write initial status");
        write_byte(8'h11, 1'b1);
        write_byte(8'h22, 1'b1);
        stop_xfer();
        status(1'b1, "write ending status");
        wait_tag(0, 1'b0, "write op_in drop");
        check_pe(1'b0, "write parity clean");
        repeat (4) tick();
    endtask

    task automatic test_mismatch();
        logic [9:0] cfg [3] = '{{8'h41, 1'b1, 1'b1}, {8'h40, 1'b1, 1'b0}, {8'h40, 1'b0, 1'b1}};
        for (int k = 0; k < 3; k++) begin
            a_bus_out = cfg[k][9:2];
            a_bus_out_parity = cfg[k][1] ? ~^cfg[k][9:2] : ^cfg[k][9:2];
            enable = cfg[k][0];
            a_address_out = 1'b1;
            tick();
            a_select_out = 1'b1;
            a_hold_out = 1'b1;
            repeat (2) tick();
            checks++;
            if (a_select_in !== 1'b0) begin
                errors++;
                $display("FAIL select early cfg%0d: select_in=%b, required 0", k, a_select_in);
            end
            tick();
            checks++;
            if (a_select_in !== 1'b1) begin
                errors++;
                $display("FAIL select propagate cfg%0d: select_in=%b, required 1", k, a_select_in);
            end
            repeat (5) tick();
            checks++;
            if (a_operational_in !== 1'b0) begin
                errors++;
                $display("FAIL no response cfg%0d: op_in=%b, required 0", k, a_operational_in);
            end
            a_select_out = 1'b0;
            a_hold_out = 1'b0;
            repeat (2) tick();
            checks++;
            if (a_select_in !== 1'b1) begin
                errors++;
                $display("FAIL select fall early cfg%0d: select_in=%b, required 1", k, a_select_in);
            end
            tick();
            checks++;
            if (a_select_in !== 1'b0) begin
                errors++;
                $display("FAIL select fall cfg%0d: select_in=%b, required 0", k, a_select_in);
            end
            a_address_out = 1'b0;
            enable = 1'b1;
            repeat (3) tick();
        end
    endtask

    task automatic test_parity();
        exp_q = '{8'h40, 8'h00, 8'h0E};
        select_dev(8'h40);
        send_cmd(8'h01);
        status(1'b0, "parity initial status");
        write_byte(8'h11, 1'b1);
        check_pe(1'b0, "parity before bad byte");
        write_byte(8'h22, 1'b0);
        check_pe(1'b1, "parity after bad byte");
        stop_xfer();
        status(1'b0, "parity ending status");
        wait_tag(0, 1'b0, "parity op_in drop");
        check_pe(1'b1, "parity sticky");
        repeat (4) tick();
    endtask

    task automatic test_test_cmd(input string nm);
        exp_q = '{8'h40, 8'h0C};
        select_dev(8'h40);
        check_pe(1'b0, "parity cleared on select");
        send_cmd(8'h00);
        status(1'b0, nm);
        wait_tag(0, 1'b0, "test op_in drop");
        checks++;
        if (a_service_in !== 1'b0 || a_bus_in !== 8'h00) begin
            errors++;
            $display("FAIL test disconnect: service_in=%b bus_in=%h, required 0 and 00", a_service_in, a_bus_in);
        end
        repeat (4) tick();
    endtask

    task automatic start_read_one();
        exp_q = '{8'h40, 8'h00, 8'hA1};
        send_q = '{{1'b0, 8'hA1}, {1'b0, 8'hB2}, {1'b0, 8'hC3}, {1'b0, 8'hD4}};
        load_send();
        select_dev(8'h40);
        send_cmd(8'h02);
        status(1'b0, "abort initial status");
        read_byte("abort data");
    endtask

    task automatic test_abort();
        start_read_one();
        a_operational_out = 1'b0;
        repeat (2) tick();
        checks++;
        if (a_operational_in !== 1'b1) begin
            errors++;
            $display("FAIL abort latency: op_in=%b, required 1", a_operational_in);
        end
        tick();
        check_outs_zero("abort outputs");
        flush_send();
        a_operational_out = 1'b1;
        repeat (4) tick();
        test_test_cmd("test after abort");
    endtask

    task automatic test_async_reset();
        start_read_one();
        aresetn = 1'b0;
        #1;
        check_outs_zero("async reset outputs");
        flush_send();
        repeat (2) tick();
        aresetn = 1'b1;
        repeat (4) tick();
        test_test_cmd("test after reset");
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_mismatch();
        test_parity();
        test_test_cmd("test initial status");
        test_abort();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/channel_device.md
# channel_device

Device-side (control-unit) responder for the parallel channel "A" interface. It answers initial selection for one device address, latches the command, presents initial and ending status, and moves data bytes between the channel bus and two byte streams toward a local backend. It sits at the far end of the cable from the channel block: in test benches and loopback builds it is wired tag-for-tag to the channel's `a_*` ports.

## Interface

Parameters:
- `DEVICE_ADDR`, 8'h40: device address this unit responds to.

Ports:
- `aclk` in 1: clock.
- `aresetn` in 1: reset. Asynchronous and active-low; all state and outputs clear immediately on assertion.
- `enable` in 1: 0 means never respond and always propagate select.
- `a_bus_out`, `a_bus_out_parity` in 8/1: channel-to-device bus, odd parity.
- `a_operational_out`, `a_hold_out`, `a_select_out`, `a_address_out`, `a_command_out`, `a_service_out`, `a_suppress_out` in 1 each: channel tags. They are asynchronous and pass through 2-flop synchronizers. `a_hold_out` is treated as equal to `a_select_out`. `a_suppress_out` is unused.
- `a_bus_in`, `a_bus_in_parity` out 8/1: device-to-channel bus. Parity is odd and generated internally.
- `a_operational_in`, `a_select_in`, `a_address_in`, `a_status_in`, `a_service_in`, `a_request_in` out 1 each: device tags. `a_request_in` is tied 0.
- `cmd_tdata` out 8, `cmd_tvalid` out 1: latched command byte, with a 1-cycle valid pulse.
- `recv_tdata` out 8, `recv_tvalid` out 1, `recv_tready` in 1: bytes written by the channel.
- `send_tdata` in 8, `send_tvalid` in 1, `send_tready` out 1, `send_tlast` in 1: bytes read by the channel.
- `busy` out 1: high whenever `a_operational_in` is high.
- `parity_error` out 1: sticky flag, cleared at the next successful selection.

## Operation

- **Reset** (`aresetn`=0, or synced `a_operational_out`=0): every output is 0, the state is IDLE, and `recv_tvalid`=0. While `a_operational_out` is low, the block ignores all other tags.
- **Command classes**, by `cmd[1:0]`:
  - 01 WRITE: data flows to the device.
  - 10 READ: data flows from the device.
  - 11 CONTROL: no data.
  - 00 TEST: immediate status.
- **Status bytes:**
  - Initial status is 0x00; for TEST it is 0x0C.
  - Ending status is 0x0C (channel end + device end), or 0x0E if a parity error occurred during this selection.

State machine (all tag outputs registered):
- **IDLE**
  - Synced select_out=1, address_out=1, enable=1, and bus_out==DEVICE_ADDR with good parity: go to SELECTED. Raise op_in, drive bus_in=DEVICE_ADDR, clear `parity_error`.
  - Otherwise: `a_select_in` follows synced select_out.
  - Address match with bad parity: no response; select is propagated.
- **SELECTED**: one cycle later raise address_in, then go to CMD_WAIT.
- **CMD_WAIT**
  - On synced command_out=1: capture bus_out into the command register, pulse `cmd_tvalid`, and check parity. Drop address_in.
  - When command_out falls: go to INIT_STATUS.
- **INIT_STATUS**
  - Drive the status byte on bus_in, then raise status_in on the next cycle.
  - On service_out or command_out rising: drop status_in.
  - When that tag falls: TEST goes to DISCONNECT; CONTROL goes to END_STATUS; WRITE or READ goes to DATA.
- **DATA, WRITE direction**
  - Raise service_in only when the recv holding register is empty.
  - On service_out rising: capture bus_out into `recv_tdata`, set `recv_tvalid`, and check parity. Drop service_in.
  - Wait for service_out to fall, then repeat.
  - If command_out rises instead (stop): drop service_in, wait for command_out to fall, then go to END_STATUS.
- **DATA, READ direction**
  - When `send_tvalid`: pulse `send_tready` for 1 cycle, load bus_in with the byte, and remember tlast. Raise service_in one cycle after bus_in settles.
  - On service_out rising: drop service_in. After service_out falls, go to END_STATUS if tlast was set; otherwise take the next byte.
  - command_out in place of service_out means stop: go to END_STATUS.
- **END_STATUS**
  - Present the ending status as in INIT_STATUS.
  - Either service_out or command_out counts as accepted; stacking is not supported.
  - After the accepting tag falls, go to DISCONNECT.
- **DISCONNECT**: drop op_in and clear bus_in, then go to IDLE.
- **Parity error** on a command or write-data byte: set `parity_error`. The byte is still delivered and the sequence continues.
- **`recv` handshake**: `recv_tvalid` stays high until `recv_tready`. The holding register is one byte deep.

## Timing

- Channel tag edge to device tag response: 3 cycles (2 synchronizer cycles plus 1 register cycle). Select propagation uses the same 3 cycles.
- bus_in is stable for at least 1 cycle before address_in, status_in, or service_in rises, and is held until that tag falls.
- bus_out is sampled in the same cycle the synced tag is first seen high.
- op_in is dropped 1 cycle after the accepting tag for the ending status falls.
- Synced operational_out=0 at any state: all tags drop on the next cycle and the state returns to IDLE; no ending status is sent.
- `aresetn` assertion mid-transfer: all outputs drop to 0 asynchronously.

## Test plan

- **READ** (DEVICE_ADDR=0x40): channel selects 0x40 with command 0x02; backend supplies A1, B2, C3 with tlast on C3. Required bus_in sequence: 0x40 with address_in, 0x00 with status_in, A1/B2/C3 with service_in, 0x0C with status_in, then op_in falls.
- **WRITE**: command 0x01; channel answers two service_in cycles with 0x11 and 0x22, then answers the third with command_out. Required: recv delivers 0x11 then 0x22; ending status 0x0C.
- **Address mismatch**: channel selects 0x41. Required: op_in stays 0, and `a_select_in` tracks `a_select_out` with 3-cycle latency. With `enable`=0 and address 0x40, the response is the same.
- **Parity error**: WRITE where the second data byte has bad parity. Required: byte still delivered, `parity_error`=1, ending status 0x0E. The flag clears at the next selection.
- **TEST**: command 0x00. Required: initial status 0x0C, no data phase, op_in drops after status is accepted.
- **Mid-transfer abort**: operational_out drops during a READ. Required: all tags 0 within 3 cycles and the state returns to IDLE. Separately, `aresetn` low mid-transfer: all outputs 0 immediately.
